// File: rtl/insn_fetch_unit.sv
// rtl/insn_fetch_unit.sv - instruction fetch unit: PC sequencing, imem handshake, fetch timeout and misaligned-target faults
module insn_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          ACK_TIMEOUT = 16
) (
  input  logic        CLK,
  input  logic        RST_N,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] INSN,
  output logic [31:0] PC,
  output logic        insn_valid,
  input  logic        insn_taken,
  input  logic        pc_next_sel,
  input  logic [31:0] pc_target,
  output logic        fault,
  output logic [1:0]  fault_code,
  output logic [31:0] instret
);

  localparam int CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(ACK_TIMEOUT - 1);
  localparam logic [31:0]   NOP       = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    VALID = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t        state, state_next;
  logic [31:0]   pc_q, pc_next;
  logic [31:0]   insn_q, insn_next;
  logic [31:0]   instret_q, instret_next;
  logic [CW-1:0] wait_q, wait_next;
  logic [1:0]    code_q, code_next;
  logic [31:0]   pc_sel;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state     <= FETCH;
      pc_q      <= RESET_PC;
      insn_q    <= NOP;
      instret_q <= 32'd0;
      wait_q    <= '0;
      code_q    <= 2'b00;
    end else begin
      state     <= state_next;
      pc_q      <= pc_next;
      insn_q    <= insn_next;
      instret_q <= instret_next;
      wait_q    <= wait_next;
      code_q    <= code_next;
    end
  end

  always_comb begin
    state_next   = state;
    pc_next      = pc_q;
    insn_next    = insn_q;
    instret_next = instret_q;
    wait_next    = wait_q;
    code_next    = code_q;
    imem_req     = 1'b0;
    insn_valid   = 1'b0;
    fault        = 1'b0;
    pc_sel       = pc_next_sel ? pc_target : (pc_q + 32'd4);

    unique case (state)
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          insn_next  = imem_rdata;
          wait_next  = '0;
          state_next = VALID;
        end else if (wait_q == WAIT_LAST) begin
          code_next  = 2'b10;
          state_next = FAULT;
        end else begin
          wait_next = wait_q + CW'(1);
        end
      end
      VALID: begin
        insn_valid = 1'b1;
        if (insn_taken) begin
          instret_next = instret_q + 32'd1;
          // A misaligned target still retires the instruction but never updates PC.
          if (pc_next_sel && (pc_target[1:0] != 2'b00)) begin
            code_next  = 2'b01;
            state_next = FAULT;
          end else begin
            pc_next    = pc_sel;
            state_next = FETCH;
          end
        end
      end
      FAULT: begin
        fault = 1'b1;
      end
      default: begin
        state_next = FAULT;
      end
    endcase
  end

  assign imem_addr  = pc_q;
  assign PC         = pc_q;
  assign INSN       = insn_q;
  assign instret    = instret_q;
  assign fault_code = code_q;

endmodule

// File: tb/tb_insn_fetch_unit.sv
// tb/tb_insn_fetch_unit.sv - self-checking bench for insn_fetch_unit
module tb_insn_fetch_unit;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic [31:0] INSN;
  logic [31:0] PC;
  logic        insn_valid;
  logic        insn_taken = 1'b0;
  logic        pc_next_sel = 1'b0;
  logic [31:0] pc_target = 32'd0;
  logic        fault;
  logic [1:0]  fault_code;
  logic [31:0] instret;

  int checks = 0;
  int errors = 0;

  insn_fetch_unit #(.RESET_PC(32'h0000_0000), .ACK_TIMEOUT(16)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .INSN(INSN), .PC(PC), .insn_valid(insn_valid),
    .insn_taken(insn_taken), .pc_next_sel(pc_next_sel), .pc_target(pc_target),
    .fault(fault), .fault_code(fault_code), .instret(instret)
  );

  always #5 CLK = ~CLK;

  // Reference model: "holding an instruction", "faulted" and "cycles waited" flags
  logic [31:0] m_pc, m_insn, m_instret;
  bit          m_holding, m_faulted;
  int          m_waited;
  logic [1:0]  m_code;

  function automatic void model_edge(bit rst_n, bit ack, logic [31:0] rdata,
                                     bit taken, bit sel, logic [31:0] tgt);
    if (!rst_n) begin
      m_pc = 32'd0; m_insn = 32'h13; m_instret = 0;
      m_holding = 0; m_faulted = 0; m_waited = 0; m_code = 2'b00;
    end else if (m_faulted) begin
    end else if (!m_holding) begin
      if (ack) begin
        m_insn = rdata; m_holding = 1; m_waited = 0;
      end else if (m_waited + 1 >= 16) begin
        m_faulted = 1; m_code = 2'b10;
      end else begin
        m_waited++;
      end
    end else if (taken) begin
      m_instret = m_instret + 1;
      if (sel && (tgt % 4 != 0)) begin
        m_faulted = 1; m_code = 2'b01;
      end else begin
        m_pc = sel ? tgt : m_pc + 4;
        m_holding = 0;
      end
    end
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(bit rst_n, bit ack, logic [31:0] rdata,
                      bit taken, bit sel, logic [31:0] tgt);
    RST_N = rst_n; imem_ack = ack; imem_rdata = rdata;
    insn_taken = taken; pc_next_sel = sel; pc_target = tgt;
    model_edge(rst_n, ack, rdata, taken, sel, tgt);
    @(posedge CLK);
    #1;
  endtask

  typedef struct {
    bit          rst_n, ack, taken, sel;
    logic [31:0] rdata, tgt;
    bit          e_valid, e_req, e_fault;
    logic [31:0] e_pc, e_insn, e_instret;
    logic [1:0]  e_code;
  } vec_t;

  vec_t vecs[11];

  initial begin
    //             rst ack tk sel rdata          tgt            vld req flt pc           insn           ret code
    vecs[0]  = '{0, 1, 0, 0, 32'hDEADBEEF, 32'h0,       0, 1, 0, 32'h0,       32'h00000013, 0, 2'b00};
    vecs[1]  = '{1, 1, 0, 0, 32'h12345117, 32'h0,       1, 0, 0, 32'h0,       32'h12345117, 0, 2'b00};
    vecs[2]  = '{1, 1, 0, 0, 32'hFFFFFFFF, 32'h0,       1, 0, 0, 32'h0,       32'h12345117, 0, 2'b00};
    vecs[3]  = '{1, 0, 1, 0, 32'h0,        32'h0,       0, 1, 0, 32'h4,       32'h12345117, 1, 2'b00};
    vecs[4]  = '{1, 0, 1, 1, 32'h0,        32'h200,     0, 1, 0, 32'h4,       32'h12345117, 1, 2'b00};
    vecs[5]  = '{1, 1, 0, 0, 32'h00000093, 32'h0,       1, 0, 0, 32'h4,       32'h00000093, 1, 2'b00};
    vecs[6]  = '{1, 0, 1, 1, 32'h0,        32'h100,     0, 1, 0, 32'h100,     32'h00000093, 2, 2'b00};
    vecs[7]  = '{1, 1, 0, 0, 32'h00A00513, 32'h0,       1, 0, 0, 32'h100,     32'h00A00513, 2, 2'b00};
    vecs[8]  = '{1, 0, 1, 1, 32'h0,        32'h102,     0, 0, 1, 32'h100,     32'h00A00513, 3, 2'b01};
    vecs[9]  = '{1, 1, 1, 0, 32'h11111111, 32'h0,       0, 0, 1, 32'h100,     32'h00A00513, 3, 2'b01};
    vecs[10] = '{0, 1, 1, 0, 32'h22222222, 32'h0,       0, 1, 0, 32'h0,       32'h00000013, 0, 2'b00};

    @(negedge CLK);
    for (int i = 0; i < 11; i++) begin
      tick(vecs[i].rst_n, vecs[i].ack, vecs[i].rdata, vecs[i].taken, vecs[i].sel, vecs[i].tgt);
      chk($sformatf("vec%0d insn_valid", i), insn_valid, vecs[i].e_valid);
      chk($sformatf("vec%0d imem_req", i), imem_req, vecs[i].e_req);
      chk($sformatf("vec%0d fault", i), fault, vecs[i].e_fault);
      chk($sformatf("vec%0d PC", i), PC, vecs[i].e_pc);
      chk($sformatf("vec%0d imem_addr", i), imem_addr, vecs[i].e_pc);
      chk($sformatf("vec%0d INSN", i), INSN, vecs[i].e_insn);
      chk($sformatf("vec%0d instret", i), instret, vecs[i].e_instret);
      chk($sformatf("vec%0d fault_code", i), fault_code, vecs[i].e_code);
    end

    // Fetch timeout: 15 silent cycles are tolerated, the 16th faults
    tick(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 15; i++) tick(1, 0, 0, 0, 0, 0);
    chk("timeout not yet", fault, 1'b0);
    chk("timeout req still", imem_req, 1'b1);
    tick(1, 0, 0, 0, 0, 0);
    chk("timeout fault", fault, 1'b1);
    chk("timeout code", fault_code, 2'b10);
    chk("timeout req off", imem_req, 1'b0);
    tick(0, 0, 0, 0, 0, 0);
    chk("timeout reset fault", fault, 1'b0);
    chk("timeout reset req", imem_req, 1'b1);
    chk("timeout reset PC", PC, 32'h0);

    // Ack arriving on the last allowed cycle is accepted
    for (int i = 0; i < 15; i++) tick(1, 0, 0, 0, 0, 0);
    tick(1, 1, 32'hCAFE0013, 0, 0, 0);
    chk("late ack valid", insn_valid, 1'b1);
    chk("late ack fault", fault, 1'b0);
    chk("late ack insn", INSN, 32'hCAFE0013);

    // PC+4 wraps modulo 2^32
    tick(1, 0, 0, 1, 1, 32'hFFFF_FFFC);
    chk("wrap target PC", PC, 32'hFFFF_FFFC);
    tick(1, 1, 32'h13, 0, 0, 0);
    tick(1, 0, 0, 1, 0, 0);
    chk("wrap PC", PC, 32'h0);
    chk("wrap instret", instret, 32'd2);

    // Randomized run against the model
    tick(0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 3000; c++) begin
      bit          r, a, t, s;
      logic [31:0] tg;
      r  = ($urandom_range(0, 99) != 0);
      a  = ($urandom_range(0, 3) == 0);
      t  = $urandom_range(0, 1);
      s  = $urandom_range(0, 1);
      tg = $urandom;
      if ($urandom_range(0, 7) != 0) tg[1:0] = 2'b00;
      tick(r, a, $urandom, t, s, tg);
      chk("rnd imem_req", imem_req, !m_faulted && !m_holding);
      chk("rnd insn_valid", insn_valid, !m_faulted && m_holding);
      chk("rnd fault", fault, m_faulted);
      chk("rnd fault_code", fault_code, m_code);
      chk("rnd PC", PC, m_pc);
      chk("rnd imem_addr", imem_addr, m_pc);
      chk("rnd INSN", INSN, m_insn);
      chk("rnd instret", instret, m_instret);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
